// File: rtl/shared_divider_scheduler.sv
// -----------------------------------------------------------------------------
// shared_divider_scheduler
//
// One iterative radix-2 restoring unsigned divider shared by N_REQ requesters.
// A round-robin arbiter picks one request per idle cycle. The operands are
// latched, and the divider produces quotient and remainder after DATA_WIDTH
// iterations. The result is broadcast, and a one-cycle one-hot result_valid
// pulse is sent to the requester that was served.
//
// Parameters
//   N_REQ       number of requesters (2..16)
//   DATA_WIDTH  operand/result width (4..64)
//
// Ports
//   clock         system clock
//   reset         asynchronous active-high reset
//   req_valid     per-requester request
//   req_ready     one-hot grant, combinational in IDLE only
//   req_dividend  flattened operands, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   req_divisor   flattened operands, same slicing
//   result_valid  one-hot single-cycle pulse to the served requester
//   quotient      broadcast quotient, held until the next result
//   remainder     broadcast remainder, held until the next result
//   div_by_zero   high when the current result came from a zero divisor
//   busy          high while an operation is in RUN or DONE
//
// Optional build macro: SHARED_DIV_PERF_EN
//   Adds busy_cycles (saturating count of cycles occupied by operations,
//   including the accept cycle) and grant_count (16-bit wrapping per-requester
//   accept counters).
// -----------------------------------------------------------------------------
module shared_divider_scheduler #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_dividend,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_divisor,
    output logic [N_REQ-1:0]            result_valid,
    output logic [DATA_WIDTH-1:0]       quotient,
    output logic [DATA_WIDTH-1:0]       remainder,
    output logic                        div_by_zero,
    output logic                        busy
`ifdef SHARED_DIV_PERF_EN
    ,
    output logic [31:0]                 busy_cycles,
    output logic [N_REQ*16-1:0]         grant_count
`endif
);

    localparam int CNT_WIDTH = $clog2(DATA_WIDTH);
    localparam int IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE_HOT_BASE = N_REQ'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ---------------------------------------------------------------- state
    state_t                  state_reg,        state_next;
    logic [IDX_W-1:0]        last_reg,         last_next;
    logic [IDX_W-1:0]        grant_reg,        grant_next;
    logic [DATA_WIDTH-1:0]   work_reg,         work_next;     // dividend in, quotient out
    logic [DATA_WIDTH-1:0]   divisor_reg,      divisor_next;
    logic [DATA_WIDTH-1:0]   rem_reg,          rem_next;      // partial remainder
    logic [CNT_WIDTH-1:0]    cnt_reg,          cnt_next;
    logic [DATA_WIDTH-1:0]   quotient_reg,     quotient_next;
    logic [DATA_WIDTH-1:0]   remainder_reg,    remainder_next;
    logic                    dbz_reg,          dbz_next;
    logic [N_REQ-1:0]        result_valid_reg, result_valid_next;

    // ------------------------------------------------------ operand slicing
    logic [DATA_WIDTH-1:0] dividend_arr [N_REQ];
    logic [DATA_WIDTH-1:0] divisor_arr  [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign dividend_arr[gi] = req_dividend[gi*DATA_WIDTH +: DATA_WIDTH];
            assign divisor_arr[gi]  = req_divisor[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------- arbiter
    // Search starts one past the last served requester and wraps, so every
    // waiting requester is reached within N_REQ-1 grants.
    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    int               cand;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_reg) + k) % N_REQ;
            if (!arb_found && req_valid[IDX_W'(cand)]) begin
                arb_found = 1'b1;
                arb_idx   = IDX_W'(cand);
            end
        end
    end

    // Gated by reset so no grant is offered while the block is held in reset.
    always_comb begin
        req_ready = '0;
        if (state_reg == IDLE && !reset && arb_found) begin
            req_ready = ONE_HOT_BASE << arb_idx;
        end
    end

    logic transfer;
    assign transfer = |(req_valid & req_ready);

    logic [DATA_WIDTH-1:0] sel_dividend;
    logic [DATA_WIDTH-1:0] sel_divisor;
    assign sel_dividend = dividend_arr[arb_idx];
    assign sel_divisor  = divisor_arr[arb_idx];

    // ----------------------------------------------- restoring divide step
    // The trial subtract carries one extra bit so that a shifted remainder
    // with its top bit set still compares correctly against a full-scale
    // divisor; the MSB of trial is the borrow.
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH+1:0] trial;
    logic                  no_borrow;
    logic [DATA_WIDTH-1:0] step_rem;
    logic [DATA_WIDTH-1:0] step_work;

    assign shifted   = {rem_reg, work_reg[DATA_WIDTH-1]};
    assign trial     = {1'b0, shifted} - {2'b00, divisor_reg};
    assign no_borrow = ~trial[DATA_WIDTH+1];
    // Whichever value is kept is below the divisor, so it fits DATA_WIDTH bits.
    assign step_rem  = DATA_WIDTH'(no_borrow ? trial[DATA_WIDTH:0] : shifted);
    assign step_work = {work_reg[DATA_WIDTH-2:0], no_borrow};

    // ------------------------------------------------- next-state / outputs
    always_comb begin
        state_next        = state_reg;
        last_next         = last_reg;
        grant_next        = grant_reg;
        work_next         = work_reg;
        divisor_next      = divisor_reg;
        rem_next          = rem_reg;
        cnt_next          = cnt_reg;
        quotient_next     = quotient_reg;
        remainder_next    = remainder_reg;
        dbz_next          = dbz_reg;
        result_valid_next = '0;

        unique case (state_reg)
            IDLE: begin
                if (transfer) begin
                    last_next  = arb_idx;
                    grant_next = arb_idx;
                    if (sel_divisor == '0) begin
                        // No iterations: the zero-divisor result is known now.
                        state_next        = DONE;
                        quotient_next     = '1;
                        remainder_next    = sel_dividend;
                        dbz_next          = 1'b1;
                        result_valid_next = ONE_HOT_BASE << arb_idx;
                    end else begin
                        state_next   = RUN;
                        work_next    = sel_dividend;
                        divisor_next = sel_divisor;
                        rem_next     = '0;
                        cnt_next     = CNT_WIDTH'(DATA_WIDTH - 1);
                    end
                end
            end

            RUN: begin
                work_next = step_work;
                rem_next  = step_rem;
                cnt_next  = cnt_reg - 1'b1;
                if (cnt_reg == '0) begin
                    // Final iteration: publish straight into the held outputs.
                    state_next        = DONE;
                    quotient_next     = step_work;
                    remainder_next    = step_rem;
                    dbz_next          = 1'b0;
                    result_valid_next = ONE_HOT_BASE << grant_reg;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------ state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            last_reg         <= IDX_W'(N_REQ - 1);
            grant_reg        <= '0;
            work_reg         <= '0;
            divisor_reg      <= '0;
            rem_reg          <= '0;
            cnt_reg          <= '0;
            quotient_reg     <= '0;
            remainder_reg    <= '0;
            dbz_reg          <= 1'b0;
            result_valid_reg <= '0;
        end else begin
            state_reg        <= state_next;
            last_reg         <= last_next;
            grant_reg        <= grant_next;
            work_reg         <= work_next;
            divisor_reg      <= divisor_next;
            rem_reg          <= rem_next;
            cnt_reg          <= cnt_next;
            quotient_reg     <= quotient_next;
            remainder_reg    <= remainder_next;
            dbz_reg          <= dbz_next;
            result_valid_reg <= result_valid_next;
        end
    end

    assign result_valid = result_valid_reg;
    assign quotient     = quotient_reg;
    assign remainder    = remainder_reg;
    assign div_by_zero  = dbz_reg;
    assign busy         = (state_reg != IDLE);

`ifdef SHARED_DIV_PERF_EN
    // ------------------------------------------------ performance counters
    // An operation occupies its accept cycle plus every RUN/DONE cycle.
    logic [31:0] busy_cycles_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_cycles_reg <= '0;
        end else if ((busy || transfer) && (busy_cycles_reg != '1)) begin
            busy_cycles_reg <= busy_cycles_reg + 32'd1;
        end
    end

    assign busy_cycles = busy_cycles_reg;

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_grant_count
            logic [15:0] grant_count_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    grant_count_reg <= '0;
                end else if (transfer && (arb_idx == IDX_W'(gi))) begin
                    grant_count_reg <= grant_count_reg + 16'd1;
                end
            end

            assign grant_count[gi*16 +: 16] = grant_count_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_shared_divider_scheduler.sv
module tb_shared_divider_scheduler;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 200;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_dividend;
    logic [N*W-1:0] req_divisor;
    logic [N-1:0]   result_valid;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic           busy;
`ifdef SHARED_DIV_PERF_EN
    logic [31:0]    busy_cycles;
    logic [N*16-1:0] grant_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int cycle_cnt = 0;

    shared_divider_scheduler #(
        .N_REQ      (N),
        .DATA_WIDTH (W)
    ) dut (
        .clock        (clk),
        .reset        (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .result_valid (result_valid),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_by_zero  (div_by_zero),
        .busy         (busy)
`ifdef SHARED_DIV_PERF_EN
        ,
        .busy_cycles  (busy_cycles),
        .grant_count  (grant_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // One operation from one requester; returns what was observed.
    // lat counts clock edges from the accept edge to the edge at which
    // result_valid is first sampled high.
    task automatic run_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [N-1:0] ready_seen, output int lat,
                          output logic [N-1:0] rv, output logic [W-1:0] q,
                          output logic [W-1:0] r, output logic dz);
        int n;
        @(negedge clk);
        req_valid = N'(1 << idx);
        req_dividend[idx*W +: W] = a;
        req_divisor[idx*W +: W]  = b;
        #1 ready_seen = req_ready;
        @(posedge clk);
        #1;
        // Scramble the operands after acceptance; the result must not change.
        req_valid = '0;
        req_dividend[idx*W +: W] = 32'hDEAD_BEEF;
        req_divisor[idx*W +: W]  = 32'h0000_0003;
        n = 0;
        while (result_valid == '0 && n < TO) begin
            @(posedge clk);
            #1;
            n++;
        end
        lat = n + 1;
        rv  = result_valid;
        q   = quotient;
        r   = remainder;
        dz  = div_by_zero;
        $display("[TB] op req%0d %h/%h -> q=%h r=%h dz=%0d lat=%0d", idx, a, b, q, r, dz, lat);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (req_ready !== '0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        tests_run++;
        if (result_valid !== '0) begin tests_failed++; $display("FAIL reset_rv: got %b expected 0000", result_valid); end
        tests_run++;
        if (quotient !== '0) begin tests_failed++; $display("FAIL reset_q: got %h expected 0", quotient); end
        tests_run++;
        if (remainder !== '0) begin tests_failed++; $display("FAIL reset_r: got %h expected 0", remainder); end
        tests_run++;
        if (div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL reset_dz: got %b expected 0", div_by_zero); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset checked");
    endtask

    task automatic test_single_op();
        logic [N-1:0] rdy, rv;
        logic [W-1:0] q, r;
        logic dz;
        int lat;
        run_op(1, 32'd100, 32'd7, rdy, lat, rv, q, r, dz);
        tests_run++;
        if (rdy !== 4'b0010) begin tests_failed++; $display("FAIL single_ready: got %b expected 0010", rdy); end
        tests_run++;
        if (lat !== 33) begin tests_failed++; $display("FAIL single_latency: got %0d expected 33", lat); end
        tests_run++;
        if (rv !== 4'b0010) begin tests_failed++; $display("FAIL single_rv: got %b expected 0010", rv); end
        tests_run++;
        if (q !== 32'd14) begin tests_failed++; $display("FAIL single_q: got %0d expected 14", q); end
        tests_run++;
        if (r !== 32'd2) begin tests_failed++; $display("FAIL single_r: got %0d expected 2", r); end
        tests_run++;
        if (dz !== 1'b0) begin tests_failed++; $display("FAIL single_dz: got %b expected 0", dz); end
        tests_run++;
        if (result_valid !== '0) begin tests_failed++; $display("FAIL single_pulse_width: got %b expected 0000", result_valid); end
        tests_run++;
        if (quotient !== 32'd14) begin tests_failed++; $display("FAIL single_q_hold: got %0d expected 14", quotient); end
    endtask

    task automatic test_div_zero();
        logic [N-1:0] rdy, rv;
        logic [W-1:0] q, r;
        logic dz;
        int lat;
        run_op(2, 32'h1234, 32'd0, rdy, lat, rv, q, r, dz);
        tests_run++;
        if (rdy !== 4'b0100) begin tests_failed++; $display("FAIL dz_ready: got %b expected 0100", rdy); end
        tests_run++;
        if (lat !== 1) begin tests_failed++; $display("FAIL dz_latency: got %0d expected 1", lat); end
        tests_run++;
        if (rv !== 4'b0100) begin tests_failed++; $display("FAIL dz_rv: got %b expected 0100", rv); end
        tests_run++;
        if (q !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL dz_q: got %h expected ffffffff", q); end
        tests_run++;
        if (r !== 32'h1234) begin tests_failed++; $display("FAIL dz_r: got %h expected 00001234", r); end
        tests_run++;
        if (dz !== 1'b1) begin tests_failed++; $display("FAIL dz_flag: got %b expected 1", dz); end
    endtask

    task automatic test_full_scale();
        logic [W-1:0] va [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
        logic [W-1:0] vb [3] = '{32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [W-1:0] eq [3] = '{32'hFFFF_FFFF, 32'd1, 32'd0};
        logic [W-1:0] er [3] = '{32'd0, 32'd0, 32'd5};
        logic [N-1:0] rdy, rv;
        logic [W-1:0] q, r;
        logic dz;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(0, va[i], vb[i], rdy, lat, rv, q, r, dz);
            tests_run++;
            if (q !== eq[i] || rv !== 4'b0001) begin
                tests_failed++;
                $display("FAIL full_q%0d: got q=%h rv=%b expected q=%h rv=0001", i, q, rv, eq[i]);
            end
            tests_run++;
            if (r !== er[i]) begin tests_failed++; $display("FAIL full_r%0d: got %h expected %h", i, r, er[i]); end
            tests_run++;
            if (dz !== 1'b0) begin tests_failed++; $display("FAIL full_dz%0d: got %b expected 0", i, dz); end
        end
    endtask

    task automatic test_round_robin();
        int exp_order [7] = '{0, 1, 2, 3, 0, 2, 0};
        int prev_cycle;
        int n;
        int g_idx;
        for (int i = 0; i < N; i++) begin
            req_dividend[i*W +: W] = 32'(100 + 10 * i);
            req_divisor[i*W +: W]  = 32'(i + 1);
        end
        @(negedge clk);
        rst = 1'b1;
        req_valid = '1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        prev_cycle = 0;
        for (int g = 0; g < 7; g++) begin
            n = 0;
            while (req_ready == '0 && n < TO) begin
                @(negedge clk);
                #1;
                n++;
            end
            g_idx = -1;
            for (int i = 0; i < N; i++) if (req_ready == N'(1 << i)) g_idx = i;
            $display("[TB] rr grant %0d -> req%0d at cycle %0d", g, g_idx, cycle_cnt);
            tests_run++;
            if (g_idx !== exp_order[g]) begin
                tests_failed++;
                $display("FAIL rr_order%0d: got req%0d (ready=%b) expected req%0d", g, g_idx, req_ready, exp_order[g]);
            end
            if (g > 0) begin
                tests_run++;
                if (cycle_cnt - prev_cycle !== 34) begin
                    tests_failed++;
                    $display("FAIL rr_spacing%0d: got %0d expected 34", g, cycle_cnt - prev_cycle);
                end
            end
            prev_cycle = cycle_cnt;
            @(posedge clk);
            #1;
            if (g == 4) req_valid = 4'b0101;
            if (g == 6) req_valid = '0;
        end
        n = 0;
        while (busy && n < TO) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        logic rv_seen;
        @(negedge clk);
        req_valid = 4'b1000;
        req_dividend[3*W +: W] = 32'd1000;
        req_divisor[3*W +: W]  = 32'd3;
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        tests_run++;
        if (quotient !== '0) begin tests_failed++; $display("FAIL midrst_q: got %h expected 0", quotient); end
        tests_run++;
        if (remainder !== '0) begin tests_failed++; $display("FAIL midrst_r: got %h expected 0", remainder); end
        tests_run++;
        if (result_valid !== '0 || div_by_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_rv_dz: got rv=%b dz=%b expected 0000/0", result_valid, div_by_zero);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b1001;
        req_dividend[0*W +: W] = 32'd50;
        req_divisor[0*W +: W]  = 32'd5;
        req_dividend[3*W +: W] = 32'd7;
        req_divisor[3*W +: W]  = 32'd2;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL midrst_ptr: got %b expected 0001", req_ready); end
        @(posedge clk);
        #1;
        req_valid = '0;
        rv_seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (result_valid != '0) rv_seen = 1'b1;
        end
        tests_run++;
        if (rv_seen !== 1'b0) begin tests_failed++; $display("FAIL midrst_stale_pulse: got 1 expected 0"); end
        n = 0;
        while (result_valid == '0 && n < TO) begin
            @(posedge clk);
            #1;
            n++;
        end
        $display("[TB] op after reset -> rv=%b q=%0d r=%0d", result_valid, quotient, remainder);
        tests_run++;
        if (result_valid !== 4'b0001) begin tests_failed++; $display("FAIL midrst_new_rv: got %b expected 0001", result_valid); end
        tests_run++;
        if (quotient !== 32'd10 || remainder !== 32'd0) begin
            tests_failed++;
            $display("FAIL midrst_new_result: got q=%0d r=%0d expected q=10 r=0", quotient, remainder);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef SHARED_DIV_PERF_EN
    task automatic test_perf();
        logic [N-1:0] rdy, rv;
        logic [W-1:0] q, r;
        logic dz;
        int lat;
        pulse_reset();
        for (int i = 0; i < 3; i++) run_op(0, 32'd10, 32'd3, rdy, lat, rv, q, r, dz);
        run_op(1, 32'h1234, 32'd0, rdy, lat, rv, q, r, dz);
        tests_run++;
        if (grant_count[15:0] !== 16'd3) begin tests_failed++; $display("FAIL perf_grant0: got %0d expected 3", grant_count[15:0]); end
        tests_run++;
        if (grant_count[31:16] !== 16'd1) begin tests_failed++; $display("FAIL perf_grant1: got %0d expected 1", grant_count[31:16]); end
        tests_run++;
        if (busy_cycles !== 32'd104) begin tests_failed++; $display("FAIL perf_busy_cycles: got %0d expected 104", busy_cycles); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_dividend = '0;
        req_divisor = '0;
        test_reset();
        test_single_op();
        test_div_zero();
        test_full_scale();
        test_round_robin();
        test_reset_mid_run();
`ifdef SHARED_DIV_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
